// File: rtl/timer_preset_editor_pkg.sv
// Shared types and constants for the timer preset editor.
package timer_preset_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EDIT_H = 3'd1,
    ST_EDIT_M = 3'd2,
    ST_EDIT_S = 3'd3,
    ST_ARM    = 3'd4,
    ST_RUN    = 3'd5,
    ST_PAUSE  = 3'd6
  } state_t;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_H    = 2'd1;
  localparam logic [1:0] FIELD_M    = 2'd2;
  localparam logic [1:0] FIELD_S    = 2'd3;

  localparam logic [7:0] BCD_MAX_MIN_SEC = 8'h59;
  localparam logic [7:0] BCD_MAX_HOUR    = 8'h23;

  // Two-digit packed BCD of a small binary constant.
  function automatic logic [7:0] bin_to_bcd(input int unsigned v);
    return {4'((v / 10) % 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/timer_preset_editor_bcd_wrap_step.sv
// Combinational +/-1 step of a packed-BCD field with wrap MAX_BCD <-> 0.
module bcd_wrap_step
  import timer_preset_pkg::*;
#(
  parameter logic [7:0] MAX_BCD = BCD_MAX_MIN_SEC
) (
  input  logic [7:0] value,
  input  logic       up,
  input  logic       down,
  output logic [7:0] next_value
);

  // Adjust ones and tens together so the result is always valid BCD.
  always_comb begin
    next_value = value;
    if (up && !down) begin
      if (value == MAX_BCD)
        next_value = '0;
      else if (value[3:0] == 4'd9)
        next_value = {value[7:4] + 4'd1, 4'd0};
      else
        next_value = {value[7:4], value[3:0] + 4'd1};
    end else if (down && !up) begin
      if (value == '0)
        next_value = MAX_BCD;
      else if (value[3:0] == 4'd0)
        next_value = {value[7:4] - 4'd1, 4'd9};
      else
        next_value = {value[7:4], value[3:0] - 4'd1};
    end
  end

endmodule

// File: rtl/timer_preset_editor.sv
// HH:MM:SS preset editor and run control for the countdown timer.
// Optional field blink: define TIMER_PRESET_BLINK_EN.
module timer_preset_editor
  import timer_preset_pkg::*;
#(
  parameter int unsigned MAX_HOUR = 23
`ifdef TIMER_PRESET_BLINK_EN
  , parameter int unsigned BLINK_HALF_MS = 250
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_start,
  input  logic       ring_in,
  output logic [7:0] hour_bcd_out,
  output logic [7:0] minute_bcd_out,
  output logic [7:0] second_bcd_out,
  output logic       load,
  output logic       clock_en,
  output logic [1:0] edit_field,
  output logic       blink
);

  localparam logic [7:0] HOUR_MAX_BCD = bin_to_bcd(MAX_HOUR);

  state_t     state_q, state_d;
  logic [7:0] hour_q, hour_d, minute_q, minute_d, second_q, second_d;
  logic [7:0] hour_step, minute_step, second_step;
  logic       load_q, load_d, clock_en_q, clock_en_d;
  logic [1:0] edit_field_q, edit_field_d;
  logic       act_start, act_mode, act_up, act_down, preset_nz;

  // One button acts per cycle: start > mode > up > down; up+down cancel.
  always_comb begin
    act_start = btn_start;
    act_mode  = btn_mode && !btn_start;
    act_up    = btn_up && !btn_down && !btn_start && !btn_mode;
    act_down  = btn_down && !btn_up && !btn_start && !btn_mode;
    preset_nz = (hour_q | minute_q | second_q) != '0;
  end

  bcd_wrap_step #(.MAX_BCD(HOUR_MAX_BCD)) u_hour_step (
    .value      (hour_q),
    .up         (act_up && state_q == ST_EDIT_H),
    .down       (act_down && state_q == ST_EDIT_H),
    .next_value (hour_step)
  );

  bcd_wrap_step #(.MAX_BCD(BCD_MAX_MIN_SEC)) u_minute_step (
    .value      (minute_q),
    .up         (act_up && state_q == ST_EDIT_M),
    .down       (act_down && state_q == ST_EDIT_M),
    .next_value (minute_step)
  );

  bcd_wrap_step #(.MAX_BCD(BCD_MAX_MIN_SEC)) u_second_step (
    .value      (second_q),
    .up         (act_up && state_q == ST_EDIT_S),
    .down       (act_down && state_q == ST_EDIT_S),
    .next_value (second_step)
  );

  // Next state, preset edits and next registered outputs.
  always_comb begin
    state_d  = state_q;
    hour_d   = hour_q;
    minute_d = minute_q;
    second_d = second_q;
    load_d   = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_EDIT_H, ST_EDIT_M, ST_EDIT_S: begin
        if (act_start) begin
          if (preset_nz) begin
            state_d = ST_ARM;
            load_d  = 1'b1;
          end
        end else if (act_mode) begin
          unique case (state_q)
            ST_IDLE:   state_d = ST_EDIT_H;
            ST_EDIT_H: state_d = ST_EDIT_M;
            ST_EDIT_M: state_d = ST_EDIT_S;
            default:   state_d = ST_IDLE;
          endcase
        end else begin
          // Step modules are gated by state, so unselected fields pass through.
          hour_d   = hour_step;
          minute_d = minute_step;
          second_d = second_step;
        end
      end
      ST_ARM: state_d = ST_RUN;
      ST_RUN: begin
        if (ring_in)        state_d = ST_IDLE;
        else if (act_start) state_d = ST_PAUSE;
        else if (act_mode)  state_d = ST_IDLE;
      end
      ST_PAUSE: begin
        if (ring_in)        state_d = ST_IDLE;
        else if (act_start) state_d = ST_RUN;
        else if (act_mode)  state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    clock_en_d = (state_d == ST_RUN);
    unique case (state_d)
      ST_EDIT_H: edit_field_d = FIELD_H;
      ST_EDIT_M: edit_field_d = FIELD_M;
      ST_EDIT_S: edit_field_d = FIELD_S;
      default:   edit_field_d = FIELD_NONE;
    endcase
  end

  // State, preset and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      hour_q       <= '0;
      minute_q     <= '0;
      second_q     <= '0;
      load_q       <= 1'b0;
      clock_en_q   <= 1'b0;
      edit_field_q <= FIELD_NONE;
    end else begin
      state_q      <= state_d;
      hour_q       <= hour_d;
      minute_q     <= minute_d;
      second_q     <= second_d;
      load_q       <= load_d;
      clock_en_q   <= clock_en_d;
      edit_field_q <= edit_field_d;
    end
  end

`ifdef TIMER_PRESET_BLINK_EN
  localparam int unsigned BLINK_CNT_W = $clog2(BLINK_HALF_MS + 1);
  localparam logic [BLINK_CNT_W-1:0] BLINK_LAST = BLINK_CNT_W'(BLINK_HALF_MS - 1);

  logic [BLINK_CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic                   blink_q, blink_d;
  logic                   in_edit_d;

  // Blink restarts visible on field entry and on every up/down step.
  always_comb begin
    in_edit_d   = (state_d == ST_EDIT_H) || (state_d == ST_EDIT_M) || (state_d == ST_EDIT_S);
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    if (!in_edit_d || state_d != state_q || act_up || act_down) begin
      blink_cnt_d = '0;
      blink_d     = 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end
  end

  // Blink counter and blink output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign blink = blink_q;
`else
  assign blink = 1'b0;
`endif

  assign hour_bcd_out   = hour_q;
  assign minute_bcd_out = minute_q;
  assign second_bcd_out = second_q;
  assign load           = load_q;
  assign clock_en       = clock_en_q;
  assign edit_field     = edit_field_q;

endmodule

// File: tb/tb_timer_preset_editor.sv
// Randomized and directed bench for timer_preset_editor against a behavioural model.
module tb_timer_preset_editor;

  localparam int HALF  = 4;
  localparam int MAXH  = 23;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_mode, btn_up, btn_down, btn_start, ring_in;
  logic [7:0] hour_bcd_out, minute_bcd_out, second_bcd_out;
  logic       load, clock_en, blink;
  logic [1:0] edit_field;

`ifdef TIMER_PRESET_BLINK_EN
  timer_preset_editor #(.MAX_HOUR(MAXH), .BLINK_HALF_MS(HALF)) dut (
`else
  timer_preset_editor #(.MAX_HOUR(MAXH)) dut (
`endif
    .clk            (clk),
    .rst            (rst),
    .btn_mode       (btn_mode),
    .btn_up         (btn_up),
    .btn_down       (btn_down),
    .btn_start      (btn_start),
    .ring_in        (ring_in),
    .hour_bcd_out   (hour_bcd_out),
    .minute_bcd_out (minute_bcd_out),
    .second_bcd_out (second_bcd_out),
    .load           (load),
    .clock_en       (clock_en),
    .edit_field     (edit_field),
    .blink          (blink)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1..3 editing h/m/s, 4 armed, 5 running, 6 paused.
  int m_st, m_h, m_m, m_s, m_since;
  bit m_load;

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t, o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  task automatic model_reset();
    m_st = 0; m_h = 0; m_m = 0; m_s = 0; m_since = 0; m_load = 0;
  endtask

  task automatic model_step(input bit st, input bit md, input bit up, input bit dn, input bit rg);
    int  prev;
    int  d;
    bit  stepped;
    bit  nz;
    prev    = m_st;
    stepped = 0;
    nz      = (m_h + m_m + m_s) != 0;
    m_load  = 0;
    if (m_st <= 3) begin
      if (st) begin
        if (nz) begin m_st = 4; m_load = 1; end
      end else if (md) begin
        m_st = (m_st + 1) % 4;
      end else if (up != dn && m_st != 0) begin
        stepped = 1;
        d = up ? 1 : -1;
        case (m_st)
          1: m_h = (m_h + d + MAXH + 1) % (MAXH + 1);
          2: m_m = (m_m + d + 60) % 60;
          default: m_s = (m_s + d + 60) % 60;
        endcase
      end
    end else if (m_st == 4) begin
      m_st = 5;
    end else begin
      if (rg)      m_st = 0;
      else if (st) m_st = (m_st == 5) ? 6 : 5;
      else if (md) m_st = 0;
    end
    if (m_st >= 1 && m_st <= 3 && prev == m_st && !stepped) m_since++;
    else m_since = 0;
  endtask

  function automatic bit exp_blink();
`ifdef TIMER_PRESET_BLINK_EN
    return (m_st >= 1 && m_st <= 3) ? bit'((m_since / HALF) % 2) : 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_model();
    check_eq("hour",   hour_bcd_out,   to_bcd(m_h));
    check_eq("minute", minute_bcd_out, to_bcd(m_m));
    check_eq("second", second_bcd_out, to_bcd(m_s));
    check_eq("load",   load,     m_load);
    check_eq("clk_en", clock_en, m_st == 5);
    check_eq("field",  edit_field, (m_st >= 1 && m_st <= 3) ? m_st : 0);
    check_eq("blink",  blink,    exp_blink());
  endtask

  // One clock cycle with the given buttons; compares all outputs after the edge.
  task automatic cyc(input bit st, input bit md, input bit up, input bit dn, input bit rg);
    btn_start = st; btn_mode = md; btn_up = up; btn_down = dn; ring_in = rg;
    @(posedge clk);
    #1;
    model_step(st, md, up, dn, rg);
    check_model();
    btn_start = 0; btn_mode = 0; btn_up = 0; btn_down = 0; ring_in = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic ups(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 1, 0, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_hour"},  hour_bcd_out,   8'h00);
    check_eq({tag, "_min"},   minute_bcd_out, 8'h00);
    check_eq({tag, "_sec"},   second_bcd_out, 8'h00);
    check_eq({tag, "_load"},  load,       1'b0);
    check_eq({tag, "_clken"}, clock_en,   1'b0);
    check_eq({tag, "_field"}, edit_field, 2'd0);
    check_eq({tag, "_blink"}, blink,      1'b0);
  endtask

  initial begin
    rst = 1'b1;
    btn_start = 0; btn_mode = 0; btn_up = 0; btn_down = 0; ring_in = 0;
    model_reset();
    #12;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Hour edit and minute underflow.
    cyc(0, 1, 0, 0, 0);
    ups(3);
    check_eq("t_field_h", edit_field, 2'd1);
    check_eq("t_hour_03", hour_bcd_out, 8'h03);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    check_eq("t_min_59", minute_bcd_out, 8'h59);

    // Second digit carry and wrap, hour wrap.
    cyc(0, 1, 0, 0, 0);
    ups(9);
    check_eq("t_sec_09", second_bcd_out, 8'h09);
    ups(1);
    check_eq("t_sec_10", second_bcd_out, 8'h10);
    ups(49);
    check_eq("t_sec_59", second_bcd_out, 8'h59);
    ups(1);
    check_eq("t_sec_00", second_bcd_out, 8'h00);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    ups(20);
    check_eq("t_hour_23", hour_bcd_out, 8'h23);
    ups(1);
    check_eq("t_hour_00", hour_bcd_out, 8'h00);

    // Preset 00:01:30, start/pause/resume, ring.
    cyc(0, 1, 0, 0, 0);
    ups(2);
    cyc(0, 1, 0, 0, 0);
    ups(30);
    cyc(0, 0, 1, 1, 0);
    check_eq("t_updn_sec", second_bcd_out, 8'h30);
    cyc(1, 0, 0, 0, 0);
    check_eq("t_load_1",   load, 1'b1);
    check_eq("t_load_h",   hour_bcd_out, 8'h00);
    check_eq("t_load_m",   minute_bcd_out, 8'h01);
    check_eq("t_load_s",   second_bcd_out, 8'h30);
    check_eq("t_arm_clk",  clock_en, 1'b0);
    cyc(0, 0, 0, 0, 0);
    check_eq("t_run_clk",  clock_en, 1'b1);
    check_eq("t_run_load", load, 1'b0);
    cyc(1, 0, 0, 0, 0);
    check_eq("t_pause_clk", clock_en, 1'b0);
    idle(2);
    cyc(1, 0, 0, 0, 0);
    check_eq("t_resume_clk",  clock_en, 1'b1);
    check_eq("t_resume_load", load, 1'b0);
    cyc(0, 0, 0, 0, 1);
    check_eq("t_ring_clk",   clock_en, 1'b0);
    check_eq("t_ring_field", edit_field, 2'd0);
    check_eq("t_ring_min",   minute_bcd_out, 8'h01);
    check_eq("t_ring_sec",   second_bcd_out, 8'h30);

    // Asynchronous reset mid-run.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    model_reset();
    #2;
    rst = 1'b0;

    // Zero preset: start ignored in IDLE and in EDIT_H.
    cyc(1, 0, 0, 0, 0);
    check_eq("t_zero_load", load, 1'b0);
    check_eq("t_zero_clk",  clock_en, 1'b0);
    cyc(0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check_eq("t_zero_edit", edit_field, 2'd1);

    // Start beats mode in EDIT_M.
    cyc(0, 1, 0, 0, 0);
    ups(1);
    cyc(1, 1, 0, 0, 0);
    check_eq("t_sm_load",  load, 1'b1);
    check_eq("t_sm_field", edit_field, 2'd0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);

    // Blink cadence in EDIT_S.
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    idle(13);
    cyc(0, 0, 1, 0, 0);
    idle(6);
    cyc(0, 1, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 99) < 4,
          $urandom_range(0, 99) < 7,
          $urandom_range(0, 99) < 30,
          $urandom_range(0, 99) < 25,
          $urandom_range(0, 99) < 6);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
